// File: rtl/scan_pkg.sv
// Shared constants for the 7-segment scanner: active-low segment patterns and anode idle level.
package scan_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int unsigned MAX_DIG  = 8;
    localparam logic [MAX_DIG-1:0] ANODE_OFF = '1;

    // Active-low one-hot anode pattern for digit idx (bits beyond the digit count stay high).
    function automatic logic [MAX_DIG-1:0] anode_sel(input int unsigned idx);
        logic [MAX_DIG-1:0] an;
        an = ANODE_OFF;
        an[idx] = 1'b0;
        return an;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low {g,f,e,d,c,b,a} decoder; non-BCD codes blank the digit.
module bcd_to_7seg
    import scan_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_7seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with a per-frame tear-free snapshot.
// Optional leading-zero blanking is enabled by defining SCAN_LZ_BLANK_EN.
module bcd_7seg_scanner
    import scan_pkg::*;
#(
    parameter int unsigned NUM_DIG     = 8,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NUM_DIG-1:0]   digits_i,
    input  logic [NUM_DIG-1:0]     dp_i,
    output logic [NUM_DIG-1:0]     an_o,
    output logic [6:0]             seg_o,
    output logic                   dp_o
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    logic [PW-1:0]        presc_q, presc_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [4*NUM_DIG-1:0] shadow_q;
    logic [NUM_DIG-1:0]   shdp_q;
    logic [NUM_DIG-1:0]   an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;

    logic                 tick;
    logic                 frame_start;
    logic [4*NUM_DIG-1:0] frame_dig;
    logic [NUM_DIG-1:0]   frame_dp;
    logic [3:0]           cur_bcd;
    logic                 cur_dp;
    logic [6:0]           dec_seg;
    logic                 blank;
    logic [MAX_DIG-1:0]   an_full;

    assign tick        = (presc_q == PW'(REFRESH_DIV - 1));
    assign frame_start = (idx_q == '0);

    // Digit 0 reads the live inputs so the snapshot taken on the same tick is not a frame late.
    assign frame_dig = frame_start ? digits_i : shadow_q;
    assign frame_dp  = frame_start ? dp_i     : shdp_q;

    always_comb begin
        cur_bcd = '0;
        cur_dp  = 1'b0;
        for (int unsigned k = 0; k < NUM_DIG; k++) begin
            if (idx_q == IW'(k)) begin
                cur_bcd = frame_dig[4*k +: 4];
                cur_dp  = frame_dp[k];
            end
        end
    end

    bcd_to_7seg u_dec (
        .bcd_i (cur_bcd),
        .seg_o (dec_seg)
    );

`ifdef SCAN_LZ_BLANK_EN
    // lz_mask[k] is set when digits k..NUM_DIG-1 are all zero; digit 0 is never blanked.
    logic [NUM_DIG-1:0] lz_mask;
    always_comb begin
        logic upper_zero;
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int unsigned i = 0; i + 1 < NUM_DIG; i++) begin
            upper_zero = upper_zero && (frame_dig[4*(NUM_DIG-1-i) +: 4] == 4'd0);
            lz_mask[NUM_DIG-1-i] = upper_zero;
        end
    end
    assign blank = lz_mask[idx_q];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = (idx_q == IW'(NUM_DIG - 1)) ? '0 : idx_q + 1'b1;
        an_full = anode_sel(int'(idx_q));
        an_d    = an_full[NUM_DIG-1:0];
        seg_d   = blank ? SEG_BLANK : dec_seg;
        dp_d    = ~cur_dp;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q  <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            shdp_q   <= '0;
            an_q     <= ANODE_OFF[NUM_DIG-1:0];
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
        end else begin
            presc_q <= presc_d;
            if (tick) begin
                idx_q <= idx_d;
                an_q  <= an_d;
                seg_q <= seg_d;
                dp_q  <= dp_d;
                if (frame_start) begin
                    shadow_q <= digits_i;
                    shdp_q   <= dp_i;
                end
            end
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
    assign dp_o  = dp_q;

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// Self-checking bench for bcd_7seg_scanner (NUM_DIG=4, REFRESH_DIV=4) against a tick/frame model.
// Leading-zero expectations follow SCAN_LZ_BLANK_EN when it is defined for the build.
module tb_bcd_7seg_scanner;

    localparam int ND = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;

    int n_cmp = 0;
    int n_err = 0;

    // Model: cycles since reset release, ticks taken, snapshot of the current frame.
    int unsigned cyc;
    int unsigned nticks;
    int          last_k;
    logic [15:0] snap;
    logic [3:0]  snap_dp;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    bcd_7seg_scanner #(.NUM_DIG(ND), .REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst      (rst),
        .digits_i (digits),
        .dp_i     (dp),
        .an_o     (an_o),
        .seg_o    (seg_o),
        .dp_o     (dp_o)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [15:0] frame, input int k);
        logic [15:0] upper;
        logic [3:0]  d;
        upper = frame >> (4 * k);
        d     = upper[3:0];
`ifdef SCAN_LZ_BLANK_EN
        if (k > 0 && upper == 16'd0) return 7'h7F;
`endif
        if (d > 4'd9) return 7'h7F;
        return seg_tab[d];
    endfunction

    task automatic model_reset();
        cyc     = 0;
        nticks  = 0;
        last_k  = -1;
        snap    = '0;
        snap_dp = '0;
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
    endtask

    // One clock edge, model advanced, then land 1 time unit after the edge.
    task automatic step();
        int k;
        @(posedge clk);
        if (rst) begin
            if (cyc % RD == RD - 1) begin
                k = int'(nticks % ND);
                if (k == 0) begin
                    snap    = digits;
                    snap_dp = dp;
                end
                exp_an  = ~(4'b0001 << k);
                exp_seg = ref_seg(snap, k);
                exp_dp  = ~snap_dp[k];
                last_k  = k;
                nticks++;
            end
            cyc++;
        end
        #1;
    endtask

    task automatic goto_digit(input int k);
        int budget;
        budget = 64;
        step();
        while (!(last_k == k && (cyc % RD) == 0) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL goto_digit: digit %0d not reached within bound, last=%0d", k, last_k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        digits = 16'h1234;
        dp = 4'b0000;
        model_reset();
        repeat (3) step();
        n_cmp++;
        if ({an_o, seg_o, dp_o} !== {4'hF, 7'h7F, 1'b1}) begin
            n_err++;
            $display("FAIL reset_dark: got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", an_o, seg_o, dp_o);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++;
            if (an_o !== ((i < 4) ? 4'b1111 : 4'b1110)) begin
                n_err++;
                $display("FAIL reset_first_tick: edge %0d an=%b want %b", i, an_o, (i < 4) ? 4'b1111 : 4'b1110);
            end
        end
    endtask

    task automatic test_scan();
        logic [6:0] want [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        int unsigned seen;
        seen = nticks;
        repeat (32) begin
            step();
            n_cmp++;
            if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, exp_dp}) begin
                n_err++;
                $display("FAIL scan_model: an=%b/%b seg=%h/%h dp=%b/%b", an_o, exp_an, seg_o, exp_seg, dp_o, exp_dp);
            end
            if (nticks != seen) begin
                seen = nticks;
                n_cmp++;
                if (seg_o !== want[last_k]) begin
                    n_err++;
                    $display("FAIL scan_1234: digit %0d seg=%h want %h", last_k, seg_o, want[last_k]);
                end
            end
        end
    endtask

    task automatic test_midframe();
        logic [6:0] want [6] = '{7'h24, 7'h79, 7'h00, 7'h78, 7'h02, 7'h12};
        int t;
        goto_digit(1);
        digits = 16'h5678;
        t = 0;
        while (t < 6) begin
            step();
            if ((cyc % RD) == 0) begin
                n_cmp++;
                if (seg_o !== want[t]) begin
                    n_err++;
                    $display("FAIL midframe: tick %0d seg=%h want %h", t, seg_o, want[t]);
                end
                t++;
            end
        end
    endtask

    task automatic test_invalid();
        goto_digit(3);
        digits = 16'h00A0;
        repeat (16) begin
            step();
            n_cmp++;
            if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, exp_dp}) begin
                n_err++;
                $display("FAIL invalid_model: an=%b/%b seg=%h/%h", an_o, exp_an, seg_o, exp_seg);
            end
            if ((cyc % RD) == 0 && last_k <= 1) begin
                n_cmp++;
                if (seg_o !== ((last_k == 1) ? 7'h7F : 7'h40)) begin
                    n_err++;
                    $display("FAIL invalid_00A0: digit %0d seg=%h want %h", last_k, seg_o, (last_k == 1) ? 7'h7F : 7'h40);
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] upper_want;
`ifdef SCAN_LZ_BLANK_EN
        upper_want = 7'h7F;
`else
        upper_want = 7'h40;
`endif
        goto_digit(3);
        digits = 16'h0007;
        repeat (16) begin
            step();
            if ((cyc % RD) == 0) begin
                n_cmp++;
                if (seg_o !== ((last_k == 0) ? 7'h78 : upper_want)) begin
                    n_err++;
                    $display("FAIL lz_0007: digit %0d seg=%h want %h", last_k, seg_o, (last_k == 0) ? 7'h78 : upper_want);
                end
            end
        end
        goto_digit(3);
        digits = 16'h0000;
        goto_digit(0);
        n_cmp++;
        if (seg_o !== 7'h40) begin
            n_err++;
            $display("FAIL lz_0000: digit0 seg=%h want 40", seg_o);
        end
    endtask

    task automatic test_dp();
        goto_digit(3);
        digits = 16'h9876;
        dp = 4'b0100;
        repeat (32) begin
            step();
            n_cmp++;
            if (dp_o !== ((exp_an == 4'b1011) ? 1'b0 : 1'b1) || an_o !== exp_an) begin
                n_err++;
                $display("FAIL dp_digit2: an=%b want %b dp=%b want %b", an_o, exp_an, dp_o, (exp_an == 4'b1011) ? 1'b0 : 1'b1);
            end
        end
        dp = 4'b0000;
    endtask

    task automatic test_mid_reset();
        goto_digit(1);
        step();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({an_o, seg_o, dp_o} !== {4'hF, 7'h7F, 1'b1}) begin
            n_err++;
            $display("FAIL mid_reset_async: an=%b seg=%h dp=%b want 1111/7f/1", an_o, seg_o, dp_o);
        end
        step();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++;
            if ({an_o, seg_o} !== ((i < 4) ? {4'b1111, 7'h7F} : {4'b1110, exp_seg})) begin
                n_err++;
                $display("FAIL mid_reset_restart: edge %0d an=%b seg=%h", i, an_o, seg_o);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        repeat (400) begin
            if ($urandom_range(0, 7) == 0) begin
                v = 16'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    for (int n = 0; n < 4; n++) v[4*n +: 4] = 4'($urandom_range(0, 9));
                    if ($urandom_range(0, 2) == 0) v[15:8] = '0;
                end
                digits = v;
                dp = 4'($urandom);
            end
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst = 1'b0;
                model_reset();
                step();
                @(negedge clk);
                rst = 1'b1;
            end
            step();
            n_cmp++;
            if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, exp_dp}) begin
                n_err++;
                $display("FAIL random: digits=%h dp=%b an=%b/%b seg=%h/%h dp_o=%b/%b",
                         digits, dp, an_o, exp_an, seg_o, exp_seg, dp_o, exp_dp);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_scan();
        test_midframe();
        test_invalid();
        test_lz();
        test_dp();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
